// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM memory port arbiter: FSM state encoding,
// grant encoding and the round-robin pick between the two pipeline sides.
package mem_port_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      D_ACCESS,
      I_ACCESS,
      D_DONE,
      I_DONE
   } arb_state_t;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // With both sides eligible the side that was not served last wins.
   function automatic logic pick_d(input logic i_ok, input logic d_ok, input logic last_grant);
      return d_ok & (~i_ok | (last_grant == GNT_I));
   endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory shared by the IF (read-only) and MEM (read/write) stages, with a
// registered request/ack handshake, per-side stall generation and an access watchdog.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   // IF side
   input  logic                i_req_i,
   input  logic [ADDR_W-1:0]   i_addr_i,
   input  logic                i_kill_i,
   output logic [DATA_W-1:0]   i_rdata_o,
   output logic                i_busywait_o,
   // MEM side
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [DATA_W/8-1:0] d_be_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                d_busywait_o,
   output logic                d_err_o,
   // Memory
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   input  logic                mem_ack_i
);

   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned WDOG_W = $clog2(TIMEOUT) + 1;
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
   localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);

   arb_state_t          state_q;
   logic                last_grant_q;
   logic [WDOG_W-1:0]   wdog_q;
   logic                kill_q;
   logic [DATA_W-1:0]   i_rdata_q;
   logic [DATA_W-1:0]   d_rdata_q;
   logic                d_err_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [BE_W-1:0]     mem_be_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   logic can_i;
   logic can_d;
   logic grant_i;
   logic grant_d;
   logic wdog_expired;
   logic access_end;
   logic fetch_killed;

   // A DONE state may hand the port straight to the other side, never to itself,
   // so the side that just finished cannot be issued twice.
   always_comb begin
      can_i = 1'b0;
      can_d = 1'b0;
      case (state_q)
         IDLE: begin
            can_i = i_req_i & ~i_kill_i;
            can_d = d_req_i;
         end
         D_DONE:  can_i = i_req_i & ~i_kill_i;
         I_DONE:  can_d = d_req_i;
         default: ;
      endcase
      grant_d      = pick_d(can_i, can_d, last_grant_q);
      grant_i      = can_i & ~grant_d;
      wdog_expired = (wdog_q == WDOG_LAST);
      access_end   = mem_ack_i | wdog_expired;
      fetch_killed = kill_q | i_kill_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         last_grant_q <= GNT_I;
         wdog_q       <= '0;
         kill_q       <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         d_err_q      <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         d_err_q <= 1'b0;
         case (state_q)
            IDLE, D_DONE, I_DONE: begin
               state_q <= IDLE;
               if (grant_d) begin
                  state_q      <= D_ACCESS;
                  mem_req_q    <= 1'b1;
                  mem_we_q     <= d_we_i;
                  mem_be_q     <= d_be_i;
                  mem_addr_q   <= d_addr_i;
                  mem_wdata_q  <= d_wdata_i;
                  last_grant_q <= GNT_D;
                  wdog_q       <= '0;
               end else if (grant_i) begin
                  state_q      <= I_ACCESS;
                  mem_req_q    <= 1'b1;
                  mem_we_q     <= 1'b0;
                  mem_be_q     <= '1;
                  mem_addr_q   <= i_addr_i;
                  mem_wdata_q  <= '0;
                  last_grant_q <= GNT_I;
                  wdog_q       <= '0;
                  kill_q       <= 1'b0;
               end
            end
            D_ACCESS: begin
               if (access_end) begin
                  mem_req_q <= 1'b0;
                  state_q   <= D_DONE;
                  d_rdata_q <= mem_ack_i ? mem_rdata_i : '0;
                  d_err_q   <= ~mem_ack_i;
               end else begin
                  wdog_q <= wdog_q + WDOG_ONE;
               end
            end
            I_ACCESS: begin
               if (i_kill_i) begin
                  kill_q <= 1'b1;
               end
               if (access_end) begin
                  mem_req_q <= 1'b0;
                  // A flushed fetch still finishes on the bus but never reaches IF.
                  if (fetch_killed) begin
                     state_q <= IDLE;
                  end else begin
                     state_q   <= I_DONE;
                     i_rdata_q <= mem_ack_i ? mem_rdata_i : '0;
                  end
               end else begin
                  wdog_q <= wdog_q + WDOG_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Gated by reset so neither pipeline stage sees a stall while the arbiter is held.
   assign i_busywait_o = rst_ni & i_req_i & (state_q != I_DONE);
   assign d_busywait_o = rst_ni & d_req_i & (state_q != D_DONE);

   assign i_rdata_o   = i_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign d_err_o     = d_err_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_be_o    = mem_be_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (read-only) and the MEM stage (read/write).
- Sequences each access with a registered request/ack handshake to memory.
- Drives the per-side busywait that stalls the IF/ID and MEM/WB pipeline registers until the access completes.
- Adds a bounded-wait watchdog so a missing ack cannot hang the core.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- TIMEOUT, 255, max cycles in an access state without mem_ack_i before forced completion; legal range 2..65535.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- i_req_i  in  1  fetch request; held stable while i_busywait_o=1.
- i_addr_i  in  ADDR_W  fetch address.
- i_kill_i  in  1  branch flush; cancels the pending fetch.
- i_rdata_o  out  DATA_W  fetched word, valid while state=I_DONE.
- i_busywait_o  out  1  stall for the IF side.
- d_req_i  in  1  data request; held stable while d_busywait_o=1.
- d_we_i  in  1  1 = store, 0 = load.
- d_be_i  in  DATA_W/8  byte enables for stores.
- d_addr_i  in  ADDR_W  data address.
- d_wdata_i  in  DATA_W  store data.
- d_rdata_o  out  DATA_W  load data, valid while state=D_DONE.
- d_busywait_o  out  1  stall for the MEM side.
- d_err_o  out  1  one-cycle pulse with D_DONE when the access timed out.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  DATA_W/8  memory byte enables.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, sampled with mem_ack_i.
- mem_ack_i  in  1  single-cycle completion from memory.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE, last_grant=I, wdog=0.
  - All mem_* outputs, rdata outputs, d_err_o = 0.
  - Both busywaits forced to 0 while reset is asserted.
- States: IDLE, D_ACCESS, I_ACCESS, D_DONE, I_DONE.
- Busywait (combinational from registered state):
  - i_busywait_o = i_req_i & ~(state==I_DONE).
  - d_busywait_o = d_req_i & ~(state==D_DONE).
- IDLE arbitration:
  - Both requests pending: grant the side not in last_grant, so the two sides alternate.
  - One request pending: grant it.
  - A fetch with i_kill_i=1 is not granted.
- On grant:
  - Register address, we, be and wdata into mem_*; mem_req_o=1 from the next cycle.
  - Fetch uses we=0, be=all ones.
  - Update last_grant; clear wdog.
- ACCESS states:
  - mem_req_o and the mem_* fields hold stable until ack.
  - mem_ack_i=1: capture mem_rdata_i into the side's rdata register, drop mem_req_o, go to the matching DONE state.
  - No ack: wdog increments.
  - wdog==TIMEOUT-1 with no ack: drop mem_req_o, rdata=0, go to DONE; D side pulses d_err_o in D_DONE.
- DONE states: last one cycle, then IDLE. The pipeline register captures on the edge that ends DONE.
- Minimum latency (zero-wait memory): req seen in cycle c0 -> mem_req_o high c1 -> ack c1 -> DONE c2 -> busywait high exactly c0..c1.
- i_kill_i:
  - Pending but not yet granted: the fetch is dropped.
  - During I_ACCESS: the memory access completes, then the FSM goes to IDLE, not I_DONE; i_rdata_o is not updated.
- A stray mem_ack_i in IDLE or DONE is ignored.
- The DONE cycle never re-grants the same side, which prevents a double issue.
- Reset during ACCESS aborts immediately: mem_req_o=0. Memory must tolerate an abandoned request.

Decomposition:
- Shared package: state enum (arb_state_t: IDLE, D_ACCESS, I_ACCESS, D_DONE, I_DONE) and grant encoding (GNT_I=0, GNT_D=1).
- Single module, no sub-module. The watchdog is a $clog2(TIMEOUT)+1-bit counter inline.

Test Plan:
- Load, zero-wait memory: d_req=1, we=0, addr=0x100, ack in the first mem_req cycle, rdata=0xDEADBEEF -> d_busywait high 2 cycles; D_DONE shows d_rdata_o=0xDEADBEEF; mem_req_o high exactly 1 cycle.
- Both requests after reset: i_req and d_req both 1 from cycle 0, ack latency 3 each -> D served first, then I; I stalls 8 cycles total; mem_addr_o order is D address then I address.
- Alternation: both requests held high for 4 accesses -> grant order D, I, D, I; neither side waits more than one foreign access.
- Store: we=1, be=4'b0011, wdata=0x12345678 -> mem_be_o=0011, mem_wdata_o=0x12345678 held until ack; no d_rdata_o change expected in the bench.
- Timeout: TIMEOUT=8, d_req, ack never arrives -> mem_req_o high 8 cycles, D_DONE with d_rdata_o=0 and a one-cycle d_err_o pulse; busywait then drops.
- Kill and reset:
  - i_kill_i pulsed during I_ACCESS -> access completes, no I_DONE, i_rdata_o unchanged.
  - rst_ni low mid-D_ACCESS -> mem_req_o=0 and busywaits=0 without waiting for a clock edge.
